// File: rtl/sys_counter_bank_pkg.sv
// Shared definitions for the SYSTEM counter bank: counter indices, selector type
// and the CSR address decode used by the execute unit.
package sys_counter_bank_pkg;

    typedef logic [4:0] t_cnt_sel;

    localparam int CNT_CYCLE      = 0;
    localparam int CNT_TIME       = 1;
    localparam int CNT_INSTRET    = 2;
    localparam int CNT_EVENT_BASE = 3;

    // Unprivileged counter CSRs sit at 0xC00..0xC1F (low) and 0xC80..0xC9F (high).
    function automatic t_cnt_sel csr_to_idx(input logic [11:0] i_addr);
        return i_addr[4:0];
    endfunction

    function automatic logic csr_is_hi(input logic [11:0] i_addr);
        return i_addr[7];
    endfunction

endpackage

// File: rtl/sys_counter_bank_counter64.sv
// One wide counter with increment enable, per-half write and a wrap pulse.
module sys_counter64
    import sys_counter_bank_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_aclk,
    input  logic                 i_reset,
    input  logic                 i_inc,
    input  logic                 i_wr_en,
    input  logic                 i_wr_hi,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_wrap
);

    logic [CNT_WIDTH-1:0] r_count;

    // A write takes precedence over the increment; no carry crosses halves.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_wr_en) begin
            if (i_wr_hi) r_count[CNT_WIDTH-1:DATA_SIZE] <= i_wr_data;
            else         r_count[DATA_SIZE-1:0]         <= i_wr_data;
        end else if (i_inc) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_inc && !i_wr_en && (&r_count);

endmodule

// File: rtl/sys_counter_bank.sv
// Bank of cycle/time/instret and event counters with registered CSR read port,
// half-word write port, inhibit mask and sticky overflow flags.
module sys_counter_bank
    import sys_counter_bank_pkg::*;
#(
    parameter  int DATA_SIZE    = 32,
    parameter  int CNT_WIDTH    = 64,
    parameter  int TIME_CNT_PER = 1024,
    parameter  int N_EVENTS     = 4,
    localparam int NUM_CNT      = 3 + N_EVENTS
) (
    input  logic                 i_aclk,
    input  logic                 i_reset,
    input  logic                 i_instret,
    input  logic [N_EVENTS-1:0]  i_events,
    input  logic [NUM_CNT-1:0]   i_inhibit,
    input  logic                 i_rd_req,
    input  logic [4:0]           i_rd_sel,
    input  logic                 i_rd_hi,
    output logic                 o_rd_valid,
    output logic [DATA_SIZE-1:0] o_rd_data,
    input  logic                 i_wr_en,
    input  logic [4:0]           i_wr_sel,
    input  logic                 i_wr_hi,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic [NUM_CNT-1:0]   i_ovf_clr,
    output logic [NUM_CNT-1:0]   o_ovf
);

    localparam int SUB_W = (TIME_CNT_PER > 2) ? $clog2(TIME_CNT_PER) : 1;
    localparam logic [NUM_CNT-1:0] INH_MASK = ~(NUM_CNT'(1) << CNT_TIME);

    if (CNT_WIDTH != 2 * DATA_SIZE) begin : g_bad_width
        $error("sys_counter_bank: CNT_WIDTH must equal 2*DATA_SIZE");
    end
    if (TIME_CNT_PER < 2) begin : g_bad_period
        $error("sys_counter_bank: TIME_CNT_PER must be >= 2");
    end
    if (N_EVENTS < 0 || N_EVENTS > 29) begin : g_bad_events
        $error("sys_counter_bank: N_EVENTS must be in 0..29");
    end

    logic [SUB_W-1:0]     r_subtime;
    logic                 w_time_tick;
    logic [NUM_CNT-1:0]   w_raw_inc;
    logic [NUM_CNT-1:0]   w_inc;
    logic [NUM_CNT-1:0]   w_wrap;
    logic [CNT_WIDTH-1:0] w_count [NUM_CNT];
    logic [DATA_SIZE-1:0] w_rd_word;
    logic                 r_rd_valid;
    logic [DATA_SIZE-1:0] r_rd_data;
    logic [NUM_CNT-1:0]   r_ovf;

    assign w_time_tick = (r_subtime == SUB_W'(TIME_CNT_PER - 1));

    always_ff @(posedge i_aclk) begin
        if (i_reset || w_time_tick) r_subtime <= '0;
        else                        r_subtime <= r_subtime + SUB_W'(1);
    end

    // Time is never frozen, so its inhibit bit is masked off.
    assign w_inc = w_raw_inc & ~(i_inhibit & INH_MASK);

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        if (i == CNT_CYCLE) begin : g_cycle
            assign w_raw_inc[i] = 1'b1;
        end else if (i == CNT_TIME) begin : g_time
            assign w_raw_inc[i] = w_time_tick;
        end else if (i == CNT_INSTRET) begin : g_instret
            assign w_raw_inc[i] = i_instret;
        end else begin : g_event
            assign w_raw_inc[i] = i_events[i - CNT_EVENT_BASE];
        end

        sys_counter64 #(
            .DATA_SIZE (DATA_SIZE),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .i_aclk    (i_aclk),
            .i_reset   (i_reset),
            .i_inc     (w_inc[i]),
            .i_wr_en   (i_wr_en && (i_wr_sel == t_cnt_sel'(i)) && (i != CNT_TIME)),
            .i_wr_hi   (i_wr_hi),
            .i_wr_data (i_wr_data),
            .o_count   (w_count[i]),
            .o_wrap    (w_wrap[i])
        );
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i_rd_sel == t_cnt_sel'(i)) begin
                w_rd_word = i_rd_hi ? w_count[i][CNT_WIDTH-1:DATA_SIZE]
                                    : w_count[i][DATA_SIZE-1:0];
            end
        end
    end

    // Read data shows pre-edge counter state; it holds when no read is issued.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_ovf      <= '0;
        end else begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req) r_rd_data <= w_rd_word;
            r_ovf <= (r_ovf & ~i_ovf_clr) | w_wrap;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_sys_counter_bank.sv
// Directed table-driven bench for sys_counter_bank (TIME_CNT_PER=4, N_EVENTS=2).
module tb_sys_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        instret;
    logic [1:0]  events;
    logic [4:0]  inhibit;
    logic        rd_req;
    logic [4:0]  rd_sel;
    logic        rd_hi;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic        wr_hi;
    logic [31:0] wr_data;
    logic [4:0]  ovf_clr;
    logic [4:0]  ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sys_counter_bank #(
        .DATA_SIZE    (32),
        .CNT_WIDTH    (64),
        .TIME_CNT_PER (4),
        .N_EVENTS     (2)
    ) dut (
        .i_aclk     (clk),
        .i_reset    (rst),
        .i_instret  (instret),
        .i_events   (events),
        .i_inhibit  (inhibit),
        .i_rd_req   (rd_req),
        .i_rd_sel   (rd_sel),
        .i_rd_hi    (rd_hi),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .i_wr_en    (wr_en),
        .i_wr_sel   (wr_sel),
        .i_wr_hi    (wr_hi),
        .i_wr_data  (wr_data),
        .i_ovf_clr  (ovf_clr),
        .o_ovf      (ovf)
    );

    typedef struct {
        logic        rd;
        logic [4:0]  rsel;
        logic        rhi;
        logic        wr;
        logic [4:0]  wsel;
        logic        whi;
        logic [31:0] wdata;
        logic        ins;
        logic [1:0]  ev;
        logic [4:0]  inh;
        logic [4:0]  clr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rd, input logic [4:0] rsel, input logic rhi,
                               input logic wr, input logic [4:0] wsel, input logic whi,
                               input logic [31:0] wdata, input logic ins, input logic [1:0] ev,
                               input logic [4:0] inh, input logic [4:0] clr,
                               input logic e_valid, input logic [31:0] e_data,
                               input logic [4:0] e_ovf);
        vec_t r;
        r.rd = rd; r.rsel = rsel; r.rhi = rhi;
        r.wr = wr; r.wsel = wsel; r.whi = whi; r.wdata = wdata;
        r.ins = ins; r.ev = ev; r.inh = inh; r.clr = clr;
        r.e_valid = e_valid; r.e_data = e_data; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instret = 1'b0; events = '0; inhibit = '0; ovf_clr = '0;
        rd_req = 1'b0; rd_sel = '0; rd_hi = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_hi = 1'b0; wr_data = '0;
    endtask

    task automatic check_out(input string tag, input logic e_valid, input logic [31:0] e_data,
                             input logic [4:0] e_ovf);
        chk({tag, " valid"}, 32'(rd_valid), 32'(e_valid));
        chk({tag, " data"}, rd_data, e_data);
        chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    endtask

    initial begin
        // Edge numbers in the notes count rising edges after reset release.
        // rd  sel  hi  wr  wsel  whi  wdata  ins ev inh clr | valid data ovf
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0));                 // e11 cycle lo
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));                  // e12 time lo
        tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));                  // e13 instret
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));                  // e14 wr cycle hi=0
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0));      // e15 wr lo=all ones
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));                  // e16 carry into hi
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));                  // e17 lo -> 0
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));                  // e18 hi -> 1
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0));      // e19 wr hi ones
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0));      // e20 wr lo ones, no ovf
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00001));           // e21 wrap
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 5'b00001)); // e22
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 5'b00001)); // e23
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 1, 5'b00001));    // e24 set beats clear
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 1, 0));           // e25 clear
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00101, 0, 1, 1, 0));           // e26 inhibit on
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00101, 0, 1, 6, 0));           // e27
        tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00101, 0, 1, 0, 0));           // e28
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00101, 0, 0, 0, 0));       // e29..e32
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00101, 0, 1, 1, 0));           // e33 cycle frozen
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0));                  // e34 time +2
        tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));                  // e35 instret frozen
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));                  // e36 retire one
        tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));                  // e37
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0));              // e38 ev0
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0));              // e39 ev0
        tbl.push_back(v(1, 3, 0, 1, 3, 0, 100, 0, 2'b01, 0, 0, 1, 2, 0));            // e40 rd+wr+event
        tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 100, 0));                // e41 no +1
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 100, 0));            // e42 ev1
        tbl.push_back(v(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));                  // e43
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'b01000, 0, 0, 1, 0));       // e44 ev0 inhibited
        tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 100, 0));                // e45
        tbl.push_back(v(1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));                 // e46 idx31
        tbl.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));                  // e47 idx5
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0));           // e48 wr time ignored
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0));                 // e49 time
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0));                 // e50 hold

        idle_inputs();
        rst = 1'b1;
        step();
        check_out("reset", 1'b0, 32'd0, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();

        for (int i = 0; i < tbl.size(); i++) begin
            rd_req = tbl[i].rd; rd_sel = tbl[i].rsel; rd_hi = tbl[i].rhi;
            wr_en = tbl[i].wr; wr_sel = tbl[i].wsel; wr_hi = tbl[i].whi; wr_data = tbl[i].wdata;
            instret = tbl[i].ins; events = tbl[i].ev; inhibit = tbl[i].inh; ovf_clr = tbl[i].clr;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ovf);
        end

        // Overflow on instret, then reset with a read and a write pending.
        idle_inputs();
        wr_en = 1'b1; wr_sel = 5'd2; wr_hi = 1'b1; wr_data = 32'hFFFF_FFFF;
        step();
        wr_hi = 1'b0;
        step();
        idle_inputs();
        instret = 1'b1;
        step();
        chk("instret wrap ovf", 32'(ovf), 32'h4);

        idle_inputs();
        rst = 1'b1;
        rd_req = 1'b1; rd_sel = 5'd0;
        wr_en = 1'b1; wr_sel = 5'd3; wr_data = 32'd55;
        step();
        check_out("reset mid-op", 1'b0, 32'd0, 5'd0);

        idle_inputs();
        rst = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_sel = 5'(i);
            step();
            check_out($sformatf("post-reset idx%0d", i), 1'b1, 32'd0, 5'd0);
        end
        rd_sel = 5'd0; rd_hi = 1'b1;
        step();
        check_out("post-reset idx0 hi", 1'b1, 32'd0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
